// File: rtl/switchbox_config_loader.sv
// Per-tile configuration loader: shifts a word stream into a shadow register, commits it atomically
// to config_out, and forwards surplus words to the next tile while the shadow register is full.
module switchbox_config_loader #(
  parameter int CONFIG_WIDTH = 384,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [WORD_WIDTH-1:0]   chain_data,
  output logic                    chain_valid,
  input  logic                    chain_ready,
  input  logic                    cfg_commit,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    cfg_full,
  output logic                    config_valid,
  output logic                    cfg_error
);

  localparam int WORDS   = CONFIG_WIDTH / WORD_WIDTH;
  localparam int COUNT_W = $clog2(WORDS + 1);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                  state, next_state;
  logic [COUNT_W-1:0]      count, next_count;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic                    transfer;

  // A start pulse overrides everything else in the cycle: it blocks the handshake and restarts from word 0.
  always_comb begin
    next_state  = state;
    next_count  = count;
    cfg_ready   = 1'b0;
    chain_valid = 1'b0;
    chain_data  = '0;
    transfer    = 1'b0;
    case (state)
      IDLE: ;
      LOAD: cfg_ready = ~cfg_start;
      FULL: begin
        cfg_ready   = chain_ready & ~cfg_start;
        chain_valid = cfg_valid & ~cfg_start;
        chain_data  = cfg_data;
        if (cfg_commit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    transfer = cfg_valid & cfg_ready;
    if (cfg_start) begin
      next_state = LOAD;
      next_count = '0;
    end else if (state == LOAD && transfer) begin
      next_count = count + 1'b1;
      if (count == LAST) next_state = FULL;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      shadow       <= '0;
      config_out   <= '0;
      cfg_full     <= 1'b0;
      config_valid <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      state    <= next_state;
      count    <= next_count;
      cfg_full <= (next_state == FULL);
      if (state == LOAD && transfer)
        shadow <= {cfg_data, shadow[CONFIG_WIDTH-1:WORD_WIDTH]};
      if (cfg_commit && state == FULL) begin
        config_out   <= shadow;
        config_valid <= 1'b1;
      end
      // A misplaced commit must stay visible even when a start arrives in the same cycle.
      if (cfg_commit && state != FULL)
        cfg_error <= 1'b1;
      else if (cfg_start)
        cfg_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switchbox_config_loader.sv
// Self-checking bench for switchbox_config_loader: directed scenarios plus randomized loads,
// all compared against a word-queue reference model of the loader.
module tb_switchbox_config_loader;

  localparam int CW    = 384;
  localparam int WW    = 32;
  localparam int WORDS = CW / WW;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_start, cfg_valid, cfg_commit, chain_ready;
  logic [WW-1:0] cfg_data;
  logic          cfg_ready, chain_valid, cfg_full, config_valid, cfg_error;
  logic [WW-1:0] chain_data;
  logic [CW-1:0] config_out;

  int tests_run = 0;
  int failures  = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = full; accepted words kept in arrival order.
  int            m_state;
  logic [WW-1:0] m_words[$];
  logic [CW-1:0] m_config;
  logic          m_cvalid, m_err;

  switchbox_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .chain_data(chain_data),
    .chain_valid(chain_valid), .chain_ready(chain_ready), .cfg_commit(cfg_commit),
    .config_out(config_out), .cfg_full(cfg_full), .config_valid(config_valid),
    .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  function automatic logic [CW-1:0] pack_words();
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < m_words.size(); k++) r[WW*k +: WW] = m_words[k];
    return r;
  endfunction

  function automatic logic exp_ready();
    return (m_state == 1 && !cfg_start) || (m_state == 2 && chain_ready && !cfg_start);
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_words.delete();
    m_config = '0;
    m_cvalid = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_edge();
    logic xfer, err_set;
    xfer    = cfg_valid && exp_ready();
    err_set = cfg_commit && m_state != 2;
    if (cfg_commit && m_state == 2) begin
      m_config = pack_words();
      m_cvalid = 1'b1;
    end
    if (cfg_start) begin
      m_words.delete();
      m_state = 1;
      m_err = 1'b0;
    end else if (m_state == 1 && xfer) begin
      m_words.push_back(cfg_data);
      if (m_words.size() == WORDS) m_state = 2;
    end else if (m_state == 2 && cfg_commit) begin
      m_state = 0;
    end
    if (err_set) m_err = 1'b1;
  endfunction

  task automatic drive(input logic s, input logic v, input logic [WW-1:0] d,
                       input logic cr, input logic c);
    @(negedge clock);
    cfg_start = s; cfg_valid = v; cfg_data = d; chain_ready = cr; cfg_commit = c;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input logic s, input logic v, input logic [WW-1:0] d,
                       input logic cr, input logic c);
    drive(s, v, d, cr, c);
    tick();
  endtask

  task automatic load_words(input logic [WW-1:0] base, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, base + WW'(k), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_start = 0; cfg_valid = 0; cfg_data = '0; chain_ready = 0; cfg_commit = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (config_out !== '0) begin failures++; $display("[TB] FAIL reset_config_out got %h want 0", config_out); end
    tests_run++;
    if ({cfg_full, config_valid, cfg_error} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_flags got %b want 000", {cfg_full, config_valid, cfg_error});
    end
    tests_run++;
    if ({cfg_ready, chain_valid} !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_handshake got %b want 00", {cfg_ready, chain_valid});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_full_load();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    load_words(32'h1000_0000, WORDS);
    tests_run++;
    if (cfg_full !== 1'b1) begin failures++; $display("[TB] FAIL full_after_12 got %b want 1", cfg_full); end
    tests_run++;
    if (config_out !== '0) begin failures++; $display("[TB] FAIL precommit_config got %h want 0", config_out); end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (config_out[31:0] !== 32'h1000_0000) begin
      failures++; $display("[TB] FAIL commit_low_word got %h want 10000000", config_out[31:0]);
    end
    tests_run++;
    if (config_out[383:352] !== 32'h1000_000B) begin
      failures++; $display("[TB] FAIL commit_high_word got %h want 1000000b", config_out[383:352]);
    end
    tests_run++;
    if (config_valid !== 1'b1 || config_out !== m_config) begin
      failures++; $display("[TB] FAIL commit_model valid=%b got %h want %h", config_valid, config_out, m_config);
    end
  endtask

  task automatic test_chain();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    load_words(32'h3000_0000, WORDS);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tests_run++;
    if ({chain_valid, cfg_ready, chain_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      failures++; $display("[TB] FAIL chain_stalled got v=%b r=%b d=%h want v=1 r=0 d=deadbeef",
                           chain_valid, cfg_ready, chain_data);
    end
    tick();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tests_run++;
    if ({chain_valid, cfg_ready} !== 2'b11) begin
      failures++; $display("[TB] FAIL chain_accept got v=%b r=%b want 11", chain_valid, cfg_ready);
    end
    tick();
    tests_run++;
    if (cfg_full !== 1'b1) begin failures++; $display("[TB] FAIL chain_still_full got %b want 1", cfg_full); end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (config_out !== m_config || config_out[383:352] !== 32'h3000_000B) begin
      failures++; $display("[TB] FAIL chain_shadow_kept got %h want %h", config_out, m_config);
    end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    load_words(32'h5555_0000, 5);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    load_words(32'h2000_0000, WORDS);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (config_out[31:0] !== 32'h2000_0000) begin
      failures++; $display("[TB] FAIL restart_low_word got %h want 20000000", config_out[31:0]);
    end
    tests_run++;
    if (config_out !== m_config) begin
      failures++; $display("[TB] FAIL restart_model got %h want %h", config_out, m_config);
    end
  endtask

  task automatic test_error();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (cfg_error !== 1'b1 || config_out !== m_config) begin
      failures++; $display("[TB] FAIL error_idle_commit err=%b got %h want err=1 %h", cfg_error, config_out, m_config);
    end
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (cfg_error !== 1'b0) begin failures++; $display("[TB] FAIL error_cleared got %b want 0", cfg_error); end
    load_words(32'h7777_0000, 2);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (cfg_error !== 1'b1) begin failures++; $display("[TB] FAIL error_load_commit got %b want 1", cfg_error); end
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (cfg_error !== 1'b1 || config_out !== m_config) begin
      failures++; $display("[TB] FAIL error_beats_start err=%b want 1", cfg_error);
    end
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (cfg_error !== m_err || cfg_error !== 1'b0) begin
      failures++; $display("[TB] FAIL error_start_clear got %b want 0", cfg_error);
    end
  endtask

  task automatic test_start_priority();
    load_words(32'h6666_0000, 3);
    drive(1'b1, 1'b1, 32'hBAD0_0000, 1'b0, 1'b0);
    tests_run++;
    if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL start_blocks_ready got %b want 0", cfg_ready); end
    tick();
    load_words(32'h4000_0000, WORDS - 1);
    tests_run++;
    if (cfg_full !== 1'b0) begin failures++; $display("[TB] FAIL count_cleared got full=%b want 0", cfg_full); end
    cycle(1'b0, 1'b1, 32'h4000_000B, 1'b0, 1'b0);
    tests_run++;
    if (cfg_full !== 1'b1) begin failures++; $display("[TB] FAIL count_reaches_full got %b want 1", cfg_full); end
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (config_out[31:0] !== 32'h4000_0000 || config_out !== m_config) begin
      failures++; $display("[TB] FAIL start_commit_update got %h want %h", config_out, m_config);
    end
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tests_run++;
    if ({cfg_full, cfg_ready, chain_valid} !== 3'b010) begin
      failures++; $display("[TB] FAIL start_commit_to_load got full/ready/chain=%b want 010",
                           {cfg_full, cfg_ready, chain_valid});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic          v, cr;
    logic [WW-1:0] d;
    int            budget;
    bit            did_reset;
    did_reset = 0;
    for (int l = 0; l < 3; l++) begin
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
      budget = 0;
      while (m_state != 2 && budget < 300) begin
        v = 1'($urandom_range(0, 1)); d = $urandom; cr = 1'($urandom_range(0, 1));
        drive(1'b0, v, d, cr, 1'b0);
        tests_run++;
        if ({cfg_ready, chain_valid, chain_data} !== {exp_ready(), 1'b0, 32'h0}) begin
          failures++; $display("[TB] FAIL rand_load_hs got r=%b cv=%b cd=%h want r=%b", cfg_ready, chain_valid,
                               chain_data, exp_ready());
        end
        tick();
        tests_run++;
        if ({cfg_full, config_valid, cfg_error} !== {m_state == 2, m_cvalid, m_err} || config_out !== m_config) begin
          failures++; $display("[TB] FAIL rand_load_state got %b %h want %b %h", {cfg_full, config_valid, cfg_error},
                               config_out, {m_state == 2, m_cvalid, m_err}, m_config);
        end
        if (l == 1 && !did_reset && m_words.size() == 6) begin
          #2 reset = 1'b1;
          #1;
          tests_run++;
          if (config_out !== '0 || {cfg_full, config_valid, cfg_error} !== 3'b000) begin
            failures++; $display("[TB] FAIL rand_async_reset got %h flags=%b want 0",
                                 config_out, {cfg_full, config_valid, cfg_error});
          end
          model_reset();
          @(negedge clock);
          reset = 1'b0;
          did_reset = 1;
          cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        budget++;
      end
      if (budget >= 300) begin
        tests_run++; failures++;
        $display("[TB] FAIL rand_timeout load=%0d words=%0d want %0d", l, m_words.size(), WORDS);
      end
      for (int j = 0; j < 4; j++) begin
        v = 1'($urandom_range(0, 1)); d = $urandom; cr = 1'($urandom_range(0, 1));
        drive(1'b0, v, d, cr, 1'b0);
        tests_run++;
        if ({cfg_ready, chain_valid, chain_data} !== {cr, v, d}) begin
          failures++; $display("[TB] FAIL rand_chain got r=%b v=%b d=%h want r=%b v=%b d=%h",
                               cfg_ready, chain_valid, chain_data, cr, v, d);
        end
        tick();
      end
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tests_run++;
      if (config_out !== m_config || config_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL rand_commit load=%0d got %h want %h", l, config_out, m_config);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_chain();
    test_restart();
    test_error();
    test_start_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
